// File: rtl/slurm16_cpu_prefetch_buffer.sv
// slurm16_cpu_prefetch_buffer
//   Instruction prefetch queue sitting between the instruction memory port and
//   pipeline stage 0. Fetch requests are issued in order ahead of demand. The
//   returned {address, instruction} pairs are buffered and presented to the
//   pipeline with a first-word-fall-through valid/ready handshake. After a
//   redirect (load_pc_request), responses that are still in flight are
//   counted and dropped.
//
// Ports
//   CLK, RST                 clock (rising edge) / asynchronous active-high reset
//   mem_request/mem_address  fetch request towards memory
//   mem_ready                memory accepts the request this cycle
//   mem_valid/mem_data/      in-order response with its address tag
//   mem_address_in
//   load_pc_request/_address redirect fetch to a new address
//   fetch_valid/fetch_ready  head-entry handshake with the pipeline
//   fetch_instruction/       head entry contents (0 when empty)
//   fetch_address
//   occupancy, full          queue fill level
//   protocol_error           sticky: bad response tag or unrequested response
module slurm16_cpu_prefetch_buffer #(
  parameter int ADDR_BITS = 15,
  parameter int DATA_BITS = 16,
  parameter int DEPTH     = 4,
  parameter logic [ADDR_BITS-1:0] RESET_ADDR = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  output logic                         mem_request,
  output logic [ADDR_BITS-1:0]         mem_address,
  input  logic                         mem_ready,
  input  logic                         mem_valid,
  input  logic [DATA_BITS-1:0]         mem_data,
  input  logic [ADDR_BITS-1:0]         mem_address_in,
  input  logic                         load_pc_request,
  input  logic [ADDR_BITS-1:0]         load_pc_address,
  input  logic                         fetch_ready,
  output logic                         fetch_valid,
  output logic [DATA_BITS-1:0]         fetch_instruction,
  output logic [ADDR_BITS-1:0]         fetch_address,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         full,
  output logic                         protocol_error
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH+1);

  logic                 start_reg;
  logic [ADDR_BITS-1:0] fetch_pc_reg;
  logic [ADDR_BITS-1:0] expected_pc_reg;
  logic [PTR_BITS-1:0]  head_reg;
  logic [PTR_BITS-1:0]  tail_reg;
  logic [CNT_BITS-1:0]  count_reg;
  logic [CNT_BITS-1:0]  outstanding_reg;
  logic [CNT_BITS-1:0]  discard_reg;
  logic                 protocol_error_reg;

  logic [ADDR_BITS-1:0] addr_mem [DEPTH];
  logic [DATA_BITS-1:0] data_mem [DEPTH];

  logic [CNT_BITS:0]    credit_sum;
  logic                 accept;
  logic                 resp_counted;
  logic                 resp_spurious;
  logic                 push;
  logic                 pop;
  logic                 tag_bad;

  // Credit covers both queued entries and every request still in flight
  // (including those whose responses will be discarded), so a kept response
  // always finds a free slot.
  assign credit_sum    = {1'b0, count_reg} + {1'b0, outstanding_reg};
  // start_reg holds off the first request until one edge after reset release.
  assign mem_request   = start_reg & (credit_sum < (CNT_BITS+1)'(DEPTH)) & ~load_pc_request;
  assign mem_address   = fetch_pc_reg;
  assign accept        = mem_request & mem_ready;

  // A response with nothing outstanding was never requested: ignore it.
  assign resp_counted  = mem_valid & (outstanding_reg != '0);
  assign resp_spurious = mem_valid & (outstanding_reg == '0);
  assign push          = resp_counted & (discard_reg == '0) & ~load_pc_request;
  assign tag_bad       = push & (mem_address_in != expected_pc_reg);

  assign fetch_valid       = (count_reg != '0);
  assign pop               = fetch_valid & fetch_ready & ~load_pc_request;
  assign fetch_instruction = fetch_valid ? data_mem[head_reg] : '0;
  assign fetch_address     = fetch_valid ? addr_mem[head_reg] : '0;
  assign occupancy         = count_reg;
  assign full              = (count_reg == CNT_BITS'(DEPTH));
  assign protocol_error    = protocol_error_reg;

  // Queue storage carries no reset; the outputs are masked while empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[tail_reg] <= mem_address_in;
      data_mem[tail_reg] <= mem_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start_reg          <= 1'b0;
      fetch_pc_reg       <= RESET_ADDR;
      expected_pc_reg    <= RESET_ADDR;
      head_reg           <= '0;
      tail_reg           <= '0;
      count_reg          <= '0;
      outstanding_reg    <= '0;
      discard_reg        <= '0;
      protocol_error_reg <= 1'b0;
    end else begin
      start_reg <= 1'b1;
      if (load_pc_request) begin
        // Everything still in flight belongs to the old stream. A response
        // arriving this very cycle has already been accounted for.
        head_reg        <= '0;
        tail_reg        <= '0;
        count_reg       <= '0;
        outstanding_reg <= outstanding_reg - CNT_BITS'(resp_counted);
        discard_reg     <= outstanding_reg - CNT_BITS'(resp_counted);
        fetch_pc_reg    <= load_pc_address;
        expected_pc_reg <= load_pc_address;
      end else begin
        fetch_pc_reg    <= fetch_pc_reg + ADDR_BITS'(accept);
        outstanding_reg <= outstanding_reg + CNT_BITS'(accept) - CNT_BITS'(resp_counted);
        if (resp_counted && discard_reg != '0)
          discard_reg <= discard_reg - CNT_BITS'(1);
        if (push) begin
          tail_reg        <= tail_reg + PTR_BITS'(1);
          expected_pc_reg <= expected_pc_reg + ADDR_BITS'(1);
        end
        if (pop)
          head_reg <= head_reg + PTR_BITS'(1);
        count_reg <= count_reg + CNT_BITS'(push) - CNT_BITS'(pop);
      end
      if (tag_bad || resp_spurious)
        protocol_error_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_slurm16_cpu_prefetch_buffer.sv
// Bench for slurm16_cpu_prefetch_buffer. A behavioural memory returns
// responses after a programmable latency. Every accepted request pushes its
// expected {tag, instruction} onto a scoreboard queue, and that queue is
// emptied on a redirect. Each pop from the DUT is compared against the front
// of the queue. Occupancy and credit expectations come from the bench's own
// count of kept responses and of requests still in flight.
module tb_slurm16_cpu_prefetch_buffer;
  localparam int AB    = 15;
  localparam int DB    = 16;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          mem_request;
  logic [AB-1:0] mem_address;
  logic          mem_ready = 1'b0;
  logic          mem_valid = 1'b0;
  logic [DB-1:0] mem_data = '0;
  logic [AB-1:0] mem_address_in = '0;
  logic          load_pc_request = 1'b0;
  logic [AB-1:0] load_pc_address = '0;
  logic          fetch_ready = 1'b0;
  logic          fetch_valid;
  logic [DB-1:0] fetch_instruction;
  logic [AB-1:0] fetch_address;
  logic [2:0]    occupancy;
  logic          full;
  logic          protocol_error;

  always #5 CLK = ~CLK;

  slurm16_cpu_prefetch_buffer #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .DEPTH(DEPTH), .RESET_ADDR('0)
  ) dut (
    .CLK(CLK), .RST(RST),
    .mem_request(mem_request), .mem_address(mem_address), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_data(mem_data), .mem_address_in(mem_address_in),
    .load_pc_request(load_pc_request), .load_pc_address(load_pc_address),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_instruction(fetch_instruction), .fetch_address(fetch_address),
    .occupancy(occupancy), .full(full), .protocol_error(protocol_error)
  );

  typedef struct { logic [AB-1:0] addr; logic [AB-1:0] tag; int epoch; int due; } req_t;
  typedef struct { logic [AB-1:0] addr; logic [DB-1:0] data; } ent_t;

  req_t pending[$];
  ent_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // stimulus controls
  int            lat = 1;
  bit            frdy = 1'b1;
  bit            frdy_rand = 1'b0;
  bit            mrdy_rand = 1'b0;
  bit            random_lpc = 1'b0;
  bit            lpc_pend = 1'b0;
  logic [AB-1:0] lpc_tgt = '0;
  bit            corrupt_en = 1'b0;
  bit            spurious = 1'b0;

  // reference state
  int            model_occ, epoch, cyc, last_due, pops;
  int            first_req_cyc, first_val_cyc;
  logic [AB-1:0] model_pc;
  bit            exp_perr, started, got_first;
  logic [AB-1:0] first_addr;
  logic [DB-1:0] first_instr;

  function automatic logic [DB-1:0] data_of(logic [AB-1:0] a);
    return {a, 1'b0} ^ 16'hC35A;
  endfunction

  task automatic check_val(string tag, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic reset_model();
    pending.delete();
    exp_q.delete();
    model_occ = 0; model_pc = '0; exp_perr = 1'b0; started = 1'b0;
    last_due = 0; cyc = 0; pops = 0; got_first = 1'b0;
    first_req_cyc = -1; first_val_cyc = -1;
  endtask

  task automatic step();
    req_t p;
    ent_t e;
    bit resp, keep, lpc, acc, popd;
    logic [AB-1:0] tag;
    int due;
    @(negedge CLK);
    lpc = lpc_pend || (random_lpc && $urandom_range(0, 19) == 0);
    if (lpc && !lpc_pend) lpc_tgt = AB'($urandom);
    load_pc_request = lpc;
    load_pc_address = lpc ? lpc_tgt : '0;
    fetch_ready = frdy_rand ? 1'($urandom_range(0, 1)) : frdy;
    mem_ready = mrdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    resp = (pending.size() > 0) && (pending[0].due <= cyc);
    if (resp) begin
      mem_valid = 1'b1; mem_data = data_of(pending[0].addr); mem_address_in = pending[0].tag;
    end else if (spurious && pending.size() == 0) begin
      mem_valid = 1'b1; mem_data = 16'hDEAD; mem_address_in = 15'h1234;
    end else begin
      mem_valid = 1'b0; mem_data = '0; mem_address_in = '0;
    end
    #1;
    check_val("mem_request", mem_request,
              started && (model_occ + pending.size() < DEPTH) && !lpc);
    check_val("fetch_valid", fetch_valid, model_occ != 0);
    check_val("occupancy", occupancy, model_occ);
    check_val("full", full, model_occ == DEPTH);
    check_val("protocol_error", protocol_error, exp_perr);
    acc = mem_request && mem_ready;
    if (acc) begin
      check_val("mem_address", mem_address, model_pc);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (fetch_valid && first_val_cyc < 0) first_val_cyc = cyc;
    popd = fetch_valid && fetch_ready && !lpc;
    if (popd) begin
      $display("pop  cycle=%0d addr=%04h instr=%04h", cyc, fetch_address, fetch_instruction);
      check_val("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("fetch_address", fetch_address, e.addr);
        check_val("fetch_instruction", fetch_instruction, e.data);
      end
      if (!got_first) begin
        got_first = 1'b1; first_addr = fetch_address; first_instr = fetch_instruction;
      end
      pops++;
      model_occ--;
    end
    if (resp) begin
      p = pending.pop_front();
      keep = (p.epoch == epoch) && !lpc;
      if (keep) begin
        model_occ++;
        if (p.tag != p.addr) exp_perr = 1'b1;
      end
    end else if (mem_valid) begin
      exp_perr = 1'b1;
    end
    if (acc) begin
      tag = (corrupt_en && model_pc == 15'h0004) ? 15'h0005 : model_pc;
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      pending.push_back('{model_pc, tag, epoch, due});
      exp_q.push_back('{tag, data_of(model_pc)});
      model_pc = model_pc + 1'b1;
    end
    if (lpc) begin
      epoch++;
      exp_q.delete();
      model_occ = 0;
      model_pc = lpc_tgt;
      lpc_pend = 1'b0;
      got_first = 1'b0;
    end
    @(posedge CLK);
    cyc++;
    started = 1'b1;
  endtask

  task automatic redirect(logic [AB-1:0] target);
    lpc_tgt = target;
    lpc_pend = 1'b1;
    step();
  endtask

  initial begin
    epoch = 0;
    reset_model();
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;

    // T1: streaming with 1-cycle memory
    lat = 1; frdy = 1'b1;
    repeat (20) step();
    check_val("t1_latency", first_val_cyc - first_req_cyc, 2);
    check_val("t1_throughput", pops, 20 - first_val_cyc);
    check_val("t1_first_addr", first_addr, 15'h0000);

    // T2: stall the pipeline until the queue fills, then drain
    frdy = 1'b0;
    repeat (10) step();
    #1;
    check_val("t2_full", full, 1);
    check_val("t2_occupancy", occupancy, DEPTH);
    check_val("t2_mem_request", mem_request, 0);
    frdy = 1'b1;
    repeat (12) step();

    // T3: 3-cycle memory, back-to-back redirects, latest one wins
    lat = 3;
    repeat (8) step();
    redirect(15'h0100);
    redirect(15'h0040);
    repeat (12) step();
    check_val("t3_first_addr", first_addr, 15'h0040);
    check_val("t3_first_instr", first_instr, data_of(15'h0040));

    // T4: address wrap at the top of the space
    lat = 1;
    redirect(15'h7FFE);
    repeat (10) step();
    check_val("t4_first_addr", first_addr, 15'h7FFE);
    check_val("t4_protocol_error", protocol_error, 0);

    // random handshakes and redirects
    lat = 2; mrdy_rand = 1'b1; frdy_rand = 1'b1; random_lpc = 1'b1;
    repeat (150) step();
    mrdy_rand = 1'b0; frdy_rand = 1'b0; random_lpc = 1'b0; frdy = 1'b1;
    repeat (10) step();

    // T5: tag mismatch on address 4, sticky through redirect
    corrupt_en = 1'b1;
    redirect(15'h0000);
    repeat (12) step();
    corrupt_en = 1'b0;
    check_val("t5_protocol_error", protocol_error, 1);
    redirect(15'h0020);
    repeat (6) step();
    check_val("t5_sticky", protocol_error, 1);

    // T6: asynchronous reset mid-cycle
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check_val("t6_fetch_valid", fetch_valid, 0);
    check_val("t6_mem_request", mem_request, 0);
    check_val("t6_occupancy", occupancy, 0);
    check_val("t6_full", full, 0);
    check_val("t6_protocol_error", protocol_error, 0);
    check_val("t6_fetch_instruction", fetch_instruction, 0);
    check_val("t6_fetch_address", fetch_address, 0);
    mem_valid = 1'b0; load_pc_request = 1'b0; fetch_ready = 1'b0; mem_ready = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b0;
    reset_model();
    lat = 1; frdy = 1'b1;
    repeat (8) step();
    check_val("t6_restart_addr", first_addr, 15'h0000);
    check_val("t6_latency", first_val_cyc - first_req_cyc, 2);

    // T7: unrequested response while full: ignored, flags an error
    frdy = 1'b0;
    repeat (10) step();
    spurious = 1'b1;
    step();
    spurious = 1'b0;
    step();
    check_val("t7_protocol_error", protocol_error, 1);
    check_val("t7_occupancy", occupancy, DEPTH);
    frdy = 1'b1;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
